// File: rtl/seq_div_32_bit.sv
// Multicycle signed restoring divider: one quotient bit per clock, fixed latency,
// one-cycle ready strobe. Divide-by-zero bypasses the iteration loop.
module seq_div_32_bit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned XW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [XW-1:0]    b_mag;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             sign_q;
  logic             sign_r;
  logic             ov;
  logic             dz_pend;

  logic [WIDTH-1:0] a_abs_c;
  logic [XW-1:0]    b_abs_c;
  logic [XW-1:0]    shifted_c;
  logic [XW-1:0]    diff_c;
  logic [WIDTH-1:0] q_fin_c;
  logic [WIDTH-1:0] r_fin_c;
  logic [WIDTH-1:0] a_back_c;
  logic             accept_c;

  // Operand magnitudes, trial subtraction and sign-corrected final values
  always_comb begin
    a_abs_c   = data_operandA[WIDTH-1] ? WIDTH'(-data_operandA) : data_operandA;
    b_abs_c   = data_operandB[WIDTH-1] ? {1'b0, WIDTH'(-data_operandB)} : {1'b0, data_operandB};
    shifted_c = {rem, quo[WIDTH-1]};
    diff_c    = shifted_c - b_mag;
    q_fin_c   = sign_q ? WIDTH'(-quo) : quo;
    r_fin_c   = sign_r ? WIDTH'(-rem) : rem;
    // quo still holds |A| on the divide-by-zero path, so this recovers A
    a_back_c  = sign_r ? WIDTH'(-quo) : quo;
    accept_c  = ctrl_DIV && ((state == DONE) || (state == IDLE && !dz_pend));
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      b_mag          <= '0;
      rem            <= '0;
      quo            <= '0;
      sign_q         <= 1'b0;
      sign_r         <= 1'b0;
      ov             <= 1'b0;
      dz_pend        <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (accept_c) begin
        b_mag   <= b_abs_c;
        quo     <= a_abs_c;
        rem     <= '0;
        cnt     <= '0;
        sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        sign_r  <= data_operandA[WIDTH-1];
        ov      <= (data_operandA == MIN_NEG) && (data_operandB == '1);
        if (data_operandB == '0) begin
          // Divide-by-zero waits one cycle in IDLE, then reports without iterating
          dz_pend <= 1'b1;
          state   <= IDLE;
        end else begin
          state   <= RUN;
          busy    <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (dz_pend) begin
              dz_pend        <= 1'b0;
              state          <= DONE;
              data_result    <= '0;
              data_remainder <= a_back_c;
              data_exception <= 1'b1;
              data_resultRDY <= 1'b1;
            end
          end
          RUN: begin
            if (cnt == CW'(WIDTH)) begin
              state          <= DONE;
              busy           <= 1'b0;
              data_result    <= q_fin_c;
              data_remainder <= r_fin_c;
              data_exception <= ov;
              data_resultRDY <= 1'b1;
            end else begin
              // Restoring step: keep the difference only when it is non-negative
              if (!diff_c[WIDTH]) begin
                rem <= diff_c[WIDTH-1:0];
              end else begin
                rem <= shifted_c[WIDTH-1:0];
              end
              quo <= {quo[WIDTH-2:0], ~diff_c[WIDTH]};
              cnt <= cnt + CW'(1);
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_div_32_bit.sv
// Scoreboard bench for seq_div_32_bit: expectations queued at start, checked on ready.
module tb_seq_div_32_bit;

  logic        clock;
  logic        reset_n;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  seq_div_32_bit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int due);
    exp_t x;
    int sa;
    int sbv;
    sa  = a;
    sbv = b;
    x.due = due;
    if (b == 32'd0) begin
      x.q = 32'd0; x.r = a; x.e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      x.q = 32'h8000_0000; x.r = 32'd0; x.e = 1'b1;
    end else begin
      x.q = 32'(sa / sbv); x.r = 32'(sa % sbv); x.e = 1'b0;
    end
    return x;
  endfunction

  // Compare every ready strobe against the oldest queued expectation
  always @(posedge clock) begin
    #1;
    if (data_resultRDY) begin
      if (sb.size() == 0) begin
        check("unexpected_rdy", 1, 0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("result", data_result, x.q);
        check("remainder", data_remainder, x.r);
        check("exception", data_exception, x.e);
        check("latency_edge", cyc, x.due);
        check("busy_at_done", busy, 0);
      end
    end
  end

  // Assert start now; it is sampled at the next rising edge
  task automatic drive_start(input logic [31:0] a, input logic [31:0] b);
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    sb.push_back(model(a, b, cyc + ((b == 32'd0) ? 1 : 33)));
    check("busy_after_start", busy, (b != 32'd0));
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    drive_start(a, b);
  endtask

  task automatic wait_rdy(input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        seen = 1;
        break;
      end
    end
    check("rdy_timeout", seen, 1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    start_op(a, b);
    wait_rdy(40);
  endtask

  initial begin
    reset_n       = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #3;
    check("rst_result", data_result, 0);
    check("rst_remainder", data_remainder, 0);
    check("rst_exception", data_exception, 0);
    check("rst_rdy", data_resultRDY, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);

    run_op(32'd100, 32'd7);
    run_op(-32'sd100, 32'd7);
    run_op(32'd100, -32'sd7);
    run_op(32'd5, 32'd0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF);
    run_op(32'h8000_0000, 32'd1);
    run_op(-32'sd7, 32'd0);
    run_op(32'd3, 32'd10);
    run_op(32'h7FFF_FFFF, 32'h8000_0000);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i == 5) rb = -rb;
      if (rb == 32'd0) rb = 32'd3;
      run_op(ra, rb);
    end

    // Start during RUN is ignored; then a back-to-back start in DONE
    start_op(32'd100, 32'd7);
    repeat (9) @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = 32'd9; data_operandB = 32'd3;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    check("busy_mid_run", busy, 1);
    wait_rdy(40);
    drive_start(32'd9, 32'd3);
    wait_rdy(40);

    // Back-to-back divide-by-zero in DONE
    start_op(32'd11, 32'd0);
    wait_rdy(5);
    drive_start(-32'sd4, 32'd0);
    wait_rdy(5);

    // Reset during RUN aborts with no ready
    start_op(32'd100, 32'd7);
    repeat (14) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrst_result", data_result, 0);
    check("midrst_remainder", data_remainder, 0);
    check("midrst_exception", data_exception, 0);
    check("midrst_busy", busy, 0);
    void'(sb.pop_front());
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(posedge clock);
    run_op(32'd1234, -32'sd5);

    repeat (3) @(posedge clock);
    check("queue_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
